// File: rtl/bbox_pkg.sv
// Shared types and helpers for the bounding-box finder.
// Optional box expansion is enabled by defining BBOX_MARGIN_EN.
package bbox_pkg;

    localparam int COORD_W = 11;
    localparam int SUM_W   = 10;
    localparam int CNT_W   = 22;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAP,
        EVAL,
        DONE
    } state_e;

    // Lower box edge minus a margin, floored at zero through a signed intermediate.
    function automatic logic [COORD_W-1:0] expand_lo(input logic [COORD_W-1:0] v,
                                                     input int unsigned        m);
        logic signed [COORD_W:0] t;
        t = $signed({1'b0, v}) - $signed((COORD_W+1)'(m));
        return t[COORD_W] ? '0 : t[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] expand_hi(input logic [COORD_W-1:0] v,
                                                     input int unsigned        m,
                                                     input logic [COORD_W-1:0] lim);
        logic [COORD_W:0] t;
        t = {1'b0, v} + (COORD_W+1)'(m);
        return (t > {1'b0, lim}) ? lim : t[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/bbox_accum.sv
// Running bounding box and foreground count for one scan.
// Cleared at scan start, updated once per foreground pixel.
module bbox_accum
    import bbox_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               hit_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               seen_o,
    output logic [COORD_W-1:0] x_min_o,
    output logic [COORD_W-1:0] x_max_o,
    output logic [COORD_W-1:0] y_min_o,
    output logic [COORD_W-1:0] y_max_o,
    output logic [CNT_W-1:0]   cnt_o
);

    logic               seen_q;
    logic [COORD_W-1:0] x_min_q, x_max_q, y_min_q, y_max_q;
    logic [CNT_W-1:0]   cnt_q;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q  <= 1'b0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            seen_q  <= 1'b0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            cnt_q   <= '0;
        end else if (hit_i) begin
            seen_q  <= 1'b1;
            x_min_q <= (!seen_q || x_i < x_min_q) ? x_i : x_min_q;
            x_max_q <= (!seen_q || x_i > x_max_q) ? x_i : x_max_q;
            y_min_q <= (!seen_q || y_i < y_min_q) ? y_i : y_min_q;
            y_max_q <= (!seen_q || y_i > y_max_q) ? y_i : y_max_q;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign seen_o  = seen_q;
    assign x_min_o = x_min_q;
    assign x_max_o = x_max_q;
    assign y_min_o = y_min_q;
    assign y_max_o = y_max_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/bbox_finder.sv
// Raster-scans a packed BGR image, thresholds B+G+R and reports the foreground bounding box.
// Define BBOX_MARGIN_EN to grow a found box by MARGIN pixels per side, clamped to the frame.
module bbox_finder
    import bbox_pkg::*;
#(
    parameter int unsigned WIDTH     = 100,
    parameter int unsigned HEIGHT    = 100,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MARGIN    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               done,
    output logic [31:0]        readAddr,
    input  logic [15:0]        readdata,
    input  logic [SUM_W-1:0]   thresh,
    output logic [COORD_W-1:0] xMin,
    output logic [COORD_W-1:0] xMax,
    output logic [COORD_W-1:0] yMin,
    output logic [COORD_W-1:0] yMax,
    output logic               found,
    output logic [CNT_W-1:0]   pixCount
);

`ifdef BBOX_MARGIN_EN
    localparam int unsigned MARGIN_ON = 1;
`else
    localparam int unsigned MARGIN_ON = 0;
`endif
    // The margin collapses to zero in the default build, leaving the box untouched.
    localparam int unsigned        PAD    = MARGIN * MARGIN_ON;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]         rgb_q, rgb_d;
    logic [SUM_W-1:0]   thr_q, thr_d;
    logic [2:0][7:0]    pix_q;
    logic               acc_clear, acc_hit, fg, last_pix;
    logic [SUM_W-1:0]   sum;

    logic               done_q, found_q;
    logic [COORD_W-1:0] x_min_q, x_max_q, y_min_q, y_max_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               acc_seen;
    logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [CNT_W-1:0]   acc_cnt;
    logic               unused_ok;

    assign unused_ok = &{1'b0, readdata[15:8]};
    assign sum       = SUM_W'(pix_q[0]) + SUM_W'(pix_q[1]) + SUM_W'(pix_q[2]);
    assign fg        = (sum >= thr_q);
    assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign readAddr  = 32'(BASE_ADDR) + 32'(y_q) * 32'(WIDTH * 3) + 32'(x_q) * 32'd3 + 32'(rgb_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        rgb_d     = rgb_q;
        thr_d     = thr_q;
        acc_clear = 1'b0;
        acc_hit   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    thr_d     = thresh;
                    x_d       = '0;
                    y_d       = '0;
                    rgb_d     = '0;
                    acc_clear = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: state_d = CAP;
            CAP: begin
                if (rgb_q < 2'd2) begin
                    rgb_d   = rgb_q + 2'd1;
                    state_d = REQ;
                end else begin
                    rgb_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                acc_hit = fg;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + COORD_W'(1);
                end else begin
                    x_d = x_q + COORD_W'(1);
                end
                state_d = last_pix ? DONE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the three byte slots are plain registers, so they share the async reset with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
            thr_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
            thr_q   <= thr_d;
            if (state_q == CAP) begin
                pix_q[rgb_q] <= readdata[7:0];
            end
        end
    end

    bbox_accum u_accum (
        .clk     (clk),
        .rst     (rst),
        .clear_i (acc_clear),
        .hit_i   (acc_hit),
        .x_i     (x_q),
        .y_i     (y_q),
        .seen_o  (acc_seen),
        .x_min_o (acc_x_min),
        .x_max_o (acc_x_max),
        .y_min_o (acc_y_min),
        .y_max_o (acc_y_max),
        .cnt_o   (acc_cnt)
    );

    // Results load one cycle into DONE, after the final pixel's update has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            found_q <= 1'b0;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= (state_q == DONE) && !start;
            if (state_q == DONE && !done_q) begin
                found_q <= acc_seen;
                cnt_q   <= acc_cnt;
                if (acc_seen) begin
                    x_min_q <= expand_lo(acc_x_min, PAD);
                    x_max_q <= expand_hi(acc_x_max, PAD, X_LAST);
                    y_min_q <= expand_lo(acc_y_min, PAD);
                    y_max_q <= expand_hi(acc_y_max, PAD, Y_LAST);
                end else begin
                    x_min_q <= '0;
                    x_max_q <= X_LAST;
                    y_min_q <= '0;
                    y_max_q <= Y_LAST;
                end
            end
        end
    end

    assign done     = done_q;
    assign found    = found_q;
    assign xMin     = x_min_q;
    assign xMax     = x_max_q;
    assign yMin     = y_min_q;
    assign yMax     = y_max_q;
    assign pixCount = cnt_q;

endmodule

// File: tb/tb_bbox_finder.sv
// Directed bench for bbox_finder on an 8x6 image with a registered byte-memory model.
// Expected boxes follow BBOX_MARGIN_EN when the bench is built with that macro.
module tb_bbox_finder;

    localparam int W      = 8;
    localparam int H      = 6;
    localparam int BASE   = 64;
    localparam int NBYTES = W * H * 3;
    localparam int SCAN   = 7 * W * H + 1;
`ifdef BBOX_MARGIN_EN
    localparam int MARGIN_ON = 1;
`else
    localparam int MARGIN_ON = 0;
`endif

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pix_t;

    typedef struct {
        string      name;
        int         npix;
        pix_t       p0;
        pix_t       p1;
        logic [9:0] thr;
        logic       found;
        int         x0, x1, y0, y1, cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  thresh;
    logic        done, found;
    logic [31:0] readAddr;
    logic [15:0] readdata;
    logic [10:0] xMin, xMax, yMin, yMax;
    logic [21:0] pixCount;

    logic [7:0]  mem [0:NBYTES-1];
    logic [31:0] off;
    int          n_checks = 0;
    int          n_errors = 0;

    bbox_finder #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .BASE_ADDR (BASE),
        .MARGIN    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .done     (done),
        .readAddr (readAddr),
        .readdata (readdata),
        .thresh   (thresh),
        .xMin     (xMin),
        .xMax     (xMax),
        .yMin     (yMin),
        .yMax     (yMax),
        .found    (found),
        .pixCount (pixCount)
    );

    always #5 clk = ~clk;

    // Registered read: data for the address seen at an edge is visible the following cycle.
    always @(posedge clk) begin
        off = readAddr - BASE;
        readdata <= (off < NBYTES) ? {8'hA5, mem[off[7:0]]} : 16'hA5EE;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'd0;
    endtask

    task automatic put_pixel(input pix_t p);
        int a;
        a = (int'(p.y) * W + int'(p.x)) * 3;
        mem[a]     = p.b;
        mem[a + 1] = p.g;
        mem[a + 2] = p.r;
    endtask

    // Accepts start, then counts cycles until done; thresh is scrambled right after acceptance.
    task automatic run_scan(input string name, input logic [9:0] thr, input int extra_at,
                            output int cycles);
        @(negedge clk);
        thresh = thr;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        thresh = 10'h3FF;
        check({name, ":done_drop"}, 32'(done), 0);
        cycles = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == extra_at);
            if (done || cycles >= 2000) break;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input vec_t v, input int cycles);
        int ex0, ex1, ey0, ey1;
        ex0 = v.x0; ex1 = v.x1; ey0 = v.y0; ey1 = v.y1;
        if (MARGIN_ON == 1 && v.found) begin
            ex0 = (ex0 - 2 < 0) ? 0 : ex0 - 2;
            ey0 = (ey0 - 2 < 0) ? 0 : ey0 - 2;
            ex1 = (ex1 + 2 > W - 1) ? W - 1 : ex1 + 2;
            ey1 = (ey1 + 2 > H - 1) ? H - 1 : ey1 + 2;
        end
        check({v.name, ":cycles"}, 32'(cycles), 32'(SCAN));
        check({v.name, ":found"},  32'(found), 32'(v.found));
        check({v.name, ":xMin"},   32'(xMin), 32'(ex0));
        check({v.name, ":xMax"},   32'(xMax), 32'(ex1));
        check({v.name, ":yMin"},   32'(yMin), 32'(ey0));
        check({v.name, ":yMax"},   32'(yMax), 32'(ey1));
        check({v.name, ":count"},  32'(pixCount), 32'(v.cnt));
    endtask

    vec_t vecs [9];
    int   cyc;

    initial begin
        pix_t none = '0;
        vecs[0] = '{"all_zero",   0, none, none, 10'd100, 1'b0, 0, 7, 0, 5, 0};
        vecs[1] = '{"single",     1, '{4'd3, 4'd2, 8'd255, 8'd255, 8'd255}, none,
                    10'd100, 1'b1, 3, 3, 2, 2, 1};
        vecs[2] = '{"two_pix",    2, '{4'd1, 4'd4, 8'd255, 8'd255, 8'd255},
                    '{4'd6, 4'd0, 8'd255, 8'd255, 8'd255}, 10'd100, 1'b1, 1, 6, 0, 4, 2};
        vecs[3] = '{"thr_300",    1, '{4'd5, 4'd5, 8'd100, 8'd100, 8'd100}, none,
                    10'd300, 1'b1, 5, 5, 5, 5, 1};
        vecs[4] = '{"thr_301",    1, '{4'd5, 4'd5, 8'd100, 8'd100, 8'd100}, none,
                    10'd301, 1'b0, 0, 7, 0, 5, 0};
        vecs[5] = '{"corners",    2, '{4'd0, 4'd0, 8'd255, 8'd255, 8'd255},
                    '{4'd7, 4'd5, 8'd255, 8'd255, 8'd255}, 10'd100, 1'b1, 0, 7, 0, 5, 2};
        vecs[6] = '{"below_thr",  2, '{4'd2, 4'd3, 8'd10, 8'd10, 8'd10},
                    '{4'd4, 4'd1, 8'd0, 8'd0, 8'd200}, 10'd100, 1'b1, 4, 4, 1, 1, 1};
        vecs[7] = '{"byte_mix",   2, '{4'd6, 4'd3, 8'd1, 8'd2, 8'd200},
                    '{4'd2, 4'd1, 8'd200, 8'd2, 8'd0}, 10'd203, 1'b1, 6, 6, 3, 3, 1};
        vecs[8] = '{"edge_0_5",   1, '{4'd0, 4'd5, 8'd255, 8'd255, 8'd255}, none,
                    10'd100, 1'b1, 0, 0, 5, 5, 1};

        rst    = 1'b1;
        start  = 1'b0;
        thresh = 10'd0;
        clear_mem();
        #12;
        check("reset:done",  32'(done), 0);
        check("reset:found", 32'(found), 0);
        check("reset:count", 32'(pixCount), 0);
        check("reset:xMax",  32'(xMax), 0);
        check("reset:yMax",  32'(yMax), 0);
        check("reset:addr",  readAddr, 32'(BASE));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            clear_mem();
            if (vecs[i].npix > 0) put_pixel(vecs[i].p0);
            if (vecs[i].npix > 1) put_pixel(vecs[i].p1);
            run_scan(vecs[i].name, vecs[i].thr, 0, cyc);
            check_result(vecs[i], cyc);
        end

        // Results must stay put while idling in DONE.
        repeat (5) @(posedge clk);
        #1;
        check("stable:done",  32'(done), 1);
        check("stable:count", 32'(pixCount), 1);

        // Start a scan, confirm old results hold, then hit it with an async reset.
        @(negedge clk);
        thresh = 10'd100;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("hold:done",  32'(done), 0);
        check("hold:count", 32'(pixCount), 1);
        check("hold:found", 32'(found), 1);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst:done",  32'(done), 0);
        check("midrst:found", 32'(found), 0);
        check("midrst:count", 32'(pixCount), 0);
        check("midrst:yMin",  32'(yMin), 0);
        check("midrst:yMax",  32'(yMax), 0);
        check("midrst:addr",  readAddr, 32'(BASE));
        @(negedge clk);
        rst = 1'b0;

        // Restart with the single-pixel image and a stray start mid-scan.
        clear_mem();
        put_pixel(vecs[1].p0);
        run_scan("restart", 10'd100, 20, cyc);
        begin
            vec_t v;
            v = vecs[1];
            v.name = "restart";
            check_result(v, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
